// File: rtl/alu_ctrl_issue.sv
// ID->EX issue stage: decodes ALUOp and operand-B select, registers the EX
// operands and control, and resolves branches from the ALU Zero/Sign flags.
module alu_ctrl_issue #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic                  id_funct7_5,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  alu_zero,
    input  logic                  alu_sign,
    output logic                  ex_valid,
    output logic [3:0]            ex_alu_op,
    output logic [XLEN-1:0]       ex_a,
    output logic [XLEN-1:0]       ex_b,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch_taken,
    output logic                  illegal_seen
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2
    } brType_e;

    logic      decLegal;
    logic [3:0] decAluOp;
    logic      decUseImm;
    logic      decRegWrite;
    logic      decMemRead;
    logic      decMemWrite;
    logic      decBranch;
    brType_e   decBrType;

    logic                  ex_valid_q,      ex_valid_d;
    logic [3:0]            ex_alu_op_q,     ex_alu_op_d;
    logic [XLEN-1:0]       ex_a_q,          ex_a_d;
    logic [XLEN-1:0]       ex_b_q,          ex_b_d;
    logic [XLEN-1:0]       ex_store_data_q, ex_store_data_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,         ex_rd_d;
    logic                  ex_reg_write_q,  ex_reg_write_d;
    logic                  ex_mem_read_q,   ex_mem_read_d;
    logic                  ex_mem_write_q,  ex_mem_write_d;
    logic                  ex_branch_q,     ex_branch_d;
    brType_e               ex_br_type_q,    ex_br_type_d;
    logic                  illegal_seen_q,  illegal_seen_d;

    logic branchTaken;
    logic issueOk;

    always_comb begin
        decLegal    = 1'b0;
        decAluOp    = ALU_ADD;
        decUseImm   = 1'b0;
        decRegWrite = 1'b0;
        decMemRead  = 1'b0;
        decMemWrite = 1'b0;
        decBranch   = 1'b0;
        decBrType   = BR_EQ;
        case (id_opcode)
            OPC_R: begin
                decRegWrite = 1'b1;
                case (id_funct3)
                    3'b000: begin
                        decLegal = 1'b1;
                        decAluOp = id_funct7_5 ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: begin
                        decLegal = 1'b1;
                        decAluOp = ALU_AND;
                    end
                    3'b110: begin
                        decLegal = 1'b1;
                        decAluOp = ALU_OR;
                    end
                    3'b001: begin
                        decLegal = ~id_funct7_5;
                        decAluOp = ALU_SLL;
                    end
                    default: decLegal = 1'b0;
                endcase
            end
            OPC_I: begin
                decRegWrite = 1'b1;
                decUseImm   = 1'b1;
                case (id_funct3)
                    3'b000: begin
                        decLegal = 1'b1;
                        decAluOp = ALU_ADD;
                    end
                    3'b111: begin
                        decLegal = 1'b1;
                        decAluOp = ALU_AND;
                    end
                    3'b110: begin
                        decLegal = 1'b1;
                        decAluOp = ALU_OR;
                    end
                    3'b001: begin
                        decLegal = 1'b1;
                        decAluOp = ALU_SLL;
                    end
                    default: decLegal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                decLegal    = (id_funct3 == 3'b011);
                decUseImm   = 1'b1;
                decMemRead  = 1'b1;
                decRegWrite = 1'b1;
            end
            OPC_STORE: begin
                decLegal    = (id_funct3 == 3'b011);
                decUseImm   = 1'b1;
                decMemWrite = 1'b1;
            end
            OPC_BRANCH: begin
                decAluOp  = ALU_SUB;
                decBranch = 1'b1;
                case (id_funct3)
                    3'b000: begin
                        decLegal  = 1'b1;
                        decBrType = BR_EQ;
                    end
                    3'b001: begin
                        decLegal  = 1'b1;
                        decBrType = BR_NE;
                    end
                    3'b100: begin
                        decLegal  = 1'b1;
                        decBrType = BR_LT;
                    end
                    default: decLegal = 1'b0;
                endcase
            end
            default: decLegal = 1'b0;
        endcase
    end

    // Branch outcome uses the live ALU flags, so it stays correct while stalled.
    always_comb begin
        branchTaken = 1'b0;
        if (ex_valid_q && ex_branch_q) begin
            case (ex_br_type_q)
                BR_EQ:   branchTaken = alu_zero;
                BR_NE:   branchTaken = ~alu_zero;
                BR_LT:   branchTaken = alu_sign;
                default: branchTaken = 1'b0;
            endcase
        end
    end

    assign issueOk = id_valid & decLegal & ~branchTaken;

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_alu_op_d     = ex_alu_op_q;
        ex_a_d          = ex_a_q;
        ex_b_d          = ex_b_q;
        ex_store_data_d = ex_store_data_q;
        ex_rd_d         = ex_rd_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_branch_d     = ex_branch_q;
        ex_br_type_d    = ex_br_type_q;
        illegal_seen_d  = illegal_seen_q;
        if (flush) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
            ex_branch_d    = 1'b0;
        end else if (!stall) begin
            ex_valid_d      = issueOk;
            ex_alu_op_d     = decAluOp;
            ex_a_d          = id_rs1_data;
            ex_b_d          = decUseImm ? id_imm : id_rs2_data;
            ex_store_data_d = id_rs2_data;
            ex_rd_d         = id_rd;
            ex_reg_write_d  = issueOk & decRegWrite;
            ex_mem_read_d   = issueOk & decMemRead;
            ex_mem_write_d  = issueOk & decMemWrite;
            ex_branch_d     = issueOk & decBranch;
            ex_br_type_d    = decBrType;
            if (id_valid && !decLegal && !branchTaken) begin
                illegal_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_alu_op_q     <= 4'b0000;
            ex_a_q          <= '0;
            ex_b_q          <= '0;
            ex_store_data_q <= '0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_branch_q     <= 1'b0;
            ex_br_type_q    <= BR_EQ;
            illegal_seen_q  <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_a_q          <= ex_a_d;
            ex_b_q          <= ex_b_d;
            ex_store_data_q <= ex_store_data_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_branch_q     <= ex_branch_d;
            ex_br_type_q    <= ex_br_type_d;
            illegal_seen_q  <= illegal_seen_d;
        end
    end

    assign ex_valid        = ex_valid_q;
    assign ex_alu_op       = ex_alu_op_q;
    assign ex_a            = ex_a_q;
    assign ex_b            = ex_b_q;
    assign ex_store_data   = ex_store_data_q;
    assign ex_rd           = ex_rd_q;
    assign ex_reg_write    = ex_reg_write_q;
    assign ex_mem_read     = ex_mem_read_q;
    assign ex_mem_write    = ex_mem_write_q;
    assign ex_branch_taken = branchTaken;
    assign illegal_seen    = illegal_seen_q;

endmodule
